psg_channel_mixer: RTL
======================

Name: psg_channel_mixer

Overview:
- Parametrised successor to the fixed 3-channel PSG audio sum in the SuperSprite card.
- Mixes NUM_CH unsigned PSG channel levels, each with a bus-programmable 4-bit gain, into one saturated OUT_W sample.
- Uses a time-multiplexed multiply-accumulate: one multiplier, one channel per clock, output updated once per sample period.
- Sits between the PSG cores (YM2149 instances, any count) and the card audio output; gain/mute registers are written by the card's slot decode logic.

Parameters:
- NUM_CH, 6, number of input channels (1..14).
- IN_W, 8, width of each channel level.
- OUT_W, 16, output sample width; must satisfy OUT_W >= IN_W+4.
- SAMPLE_DIV, 1024, clk_logic_i cycles per sample period; must be >= NUM_CH+4.

Ports:
- clk_logic_i  in  1  logic clock.
- system_reset_i  in  1  asynchronous, active-high reset.
- ch_i  in  NUM_CH*IN_W  channel levels; channel k occupies bits [k*IN_W +: IN_W].
- reg_wr_i  in  1  register write strobe, one cycle.
- reg_addr_i  in  4  register address.
- reg_data_i  in  8  write data.
- reg_data_o  out  8  combinational readback of register at reg_addr_i.
- audio_o  out  OUT_W  mixed sample, held between updates.
- sample_valid_o  out  1  one-cycle pulse when audio_o updates.
- peak_o  out  OUT_W  peak-hold value (see Optional Feature).

Behaviour:
- Reset (async, system_reset_i=1):
  - audio_o=0, sample_valid_o=0, peak_o=0.
  - All gains=8 (unity), mute=0, divider=0, FSM=IDLE, accumulator=0.
- Register map:
  - Addresses 0..NUM_CH-1: gain[k] = reg_data_i[3:0]; readback {4'b0, gain}.
  - Address 0xF: bit0 = mute; readback {7'b0, mute}.
  - 0xE is reserved for peak clear (Optional Feature).
  - All other addresses: writes ignored, read 0.
- Writes land in the live registers immediately. They take effect at the next SNAP, so a write during ACCUM never affects the sample in progress.
- Divider: counts 0..SAMPLE_DIV-1 and wraps; tick asserts on the count SAMPLE_DIV-1. The divider free-runs independent of FSM state.
- FSM:
  - IDLE: on tick -> SNAP.
  - SNAP (1 cycle): latch all of ch_i and all gains into shadow registers; clear accumulator; -> ACCUM.
  - ACCUM (NUM_CH cycles, index 0..NUM_CH-1): acc += shadow_ch[idx] * shadow_gain[idx]; after the last index -> SCALE.
  - SCALE (1 cycle): compute the output as below, register it to audio_o, pulse sample_valid_o on the following cycle; -> IDLE.
- Arithmetic:
  - acc width = IN_W + 4 + ceil(log2(NUM_CH+1)), unsigned.
  - out = (acc >> 3) << (OUT_W - IN_W - 4), so gain 8 equals the legacy {4'b0, ch, 4'b0} contribution.
  - If out exceeds 2^OUT_W - 1, saturate to all ones. No wrap is permitted.
  - mute=1 forces audio_o=0 at SCALE; sample_valid_o still pulses.
- Latency: sample_valid_o rises NUM_CH+2 cycles after the tick cycle. Period is exactly SAMPLE_DIV cycles.
- A tick occurring while not in IDLE cannot happen given the SAMPLE_DIV constraint; the design need not handle it.
- Reset mid-ACCUM:
  - No partial sample is emitted.
  - After release, the first sample_valid_o occurs NUM_CH+2 cycles after the first tick, i.e. SAMPLE_DIV+NUM_CH+1 cycles after release.

Optional Feature:
- Macro: PSG_MIXER_PEAK_EN.
- Defined:
  - peak_o holds the maximum audio_o since reset or the last clear; it updates in the same cycle audio_o updates.
  - A write to address 0xE clears peak_o to 0. If that clear coincides with a SCALE update, the new sample becomes the peak.
  - Readback at 0xE returns peak_o[OUT_W-1 -: 8].
- Undefined: peak_o is tied to 0, 0xE reads 0, and writes to 0xE are ignored.

Test Plan:
- Reset, then ch0=0xFF with others 0 at default gains -> first sample_valid_o at cycle SAMPLE_DIV+NUM_CH+1 after release; audio_o=0x0FF0.
- NUM_CH=6, all channels 0xFF, all gains written to 15 -> audio_o=0xB340.
- NUM_CH=14, all channels 0xFF, gains 15 -> audio_o saturates at 0xFFFF, with no wrap.
- Write gain[0]=0 during ACCUM with ch0=0xFF -> current sample=0x0FF0, next sample=0x0000; readback at address 0 returns 0x00.
- Write mute=1 (0xF, 0x01) -> audio_o=0 while sample_valid_o keeps pulsing every SAMPLE_DIV cycles; readback at 0xF returns 0x01.
- With PSG_MIXER_PEAK_EN: samples 0x0FF0 then 0x07F0 -> peak_o=0x0FF0; write 0xE -> peak_o=0, and the next sample 0x07F0 sets peak_o=0x07F0.

Source files
------------

// File: rtl/psg_channel_mixer_if.sv
// Register access bus of the PSG channel mixer: one-cycle write strobe plus
// a combinational readback of the addressed register.
interface psg_channel_mixer_if;
    logic       reg_wr;
    logic [3:0] reg_addr;
    logic [7:0] reg_data;
    logic [7:0] reg_rdata;

    modport master (output reg_wr, output reg_addr, output reg_data, input reg_rdata);
    modport slave  (input reg_wr, input reg_addr, input reg_data, output reg_rdata);
endinterface

// File: rtl/psg_channel_mixer.sv
// Time-multiplexed NUM_CH-channel PSG mixer with per-channel 4-bit gain, mute and
// saturation. Define PSG_MIXER_PEAK_EN to enable the peak-hold register at 0xE.
module psg_channel_mixer #(
    parameter int NUM_CH     = 6,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 16,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic                     clk_logic_i,
    input  logic                     system_reset_i,
    psg_channel_mixer_if.slave       bus,
    input  logic [NUM_CH*IN_W-1:0]   ch_i,
    output logic [OUT_W-1:0]         audio_o,
    output logic                     sample_valid_o,
    output logic [OUT_W-1:0]         peak_o
);
    localparam int AW    = IN_W + 4 + $clog2(NUM_CH + 1);
    localparam int PW    = IN_W + 4;
    localparam int SHIFT = OUT_W - IN_W - 4;
    localparam int WW    = AW + OUT_W;
    localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DW    = $clog2(SAMPLE_DIV);
    localparam logic [3:0] ADDR_PEAK = 4'hE;
    localparam logic [3:0] ADDR_MUTE = 4'hF;

    typedef enum logic [1:0] {IDLE, SNAP, ACCUM, SCALE} state_t;

    logic [IN_W-1:0]  ch_lvl    [NUM_CH];
    logic [3:0]       gain_q    [NUM_CH];
    logic [IN_W-1:0]  sh_ch_q   [NUM_CH];
    logic [3:0]       sh_gain_q [NUM_CH];
    logic             mute_q;
    logic             sh_mute_q;
    logic [DW-1:0]    div_q;
    logic             tick;
    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_d;
    logic [PW-1:0]    prod;
    logic [WW-1:0]    scaled;
    logic [OUT_W-1:0] sample_d;
    logic [OUT_W-1:0] audio_q;
    logic             valid_q;
    logic             last_idx;
    logic             sample_upd;
    logic [7:0]       rdata_d;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_lvl[gi] = ch_i[gi*IN_W +: IN_W];
    end

    // Live register file: writes land immediately, the shadows below decouple them.
    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            for (int k = 0; k < NUM_CH; k++) gain_q[k] <= 4'd8;
            mute_q <= 1'b0;
        end else if (bus.reg_wr) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.reg_addr == 4'(k)) gain_q[k] <= bus.reg_data[3:0];
            end
            if (bus.reg_addr == ADDR_MUTE) mute_q <= bus.reg_data[0];
        end
    end

    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sh_ch_q[k]   <= '0;
                sh_gain_q[k] <= 4'd8;
            end
            sh_mute_q <= 1'b0;
        end else if (state_q == SNAP) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sh_ch_q[k]   <= ch_lvl[k];
                sh_gain_q[k] <= gain_q[k];
            end
            sh_mute_q <= mute_q;
        end
    end

    assign tick = (div_q == DW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) div_q <= '0;
        else                div_q <= tick ? '0 : div_q + 1'b1;
    end

    // Single shared multiplier; the last product is folded straight into the output.
    always_comb begin
        prod       = sh_ch_q[idx_q] * sh_gain_q[idx_q];
        acc_d      = acc_q + AW'(prod);
        scaled     = WW'(acc_d >> 3) << SHIFT;
        last_idx   = (idx_q == IW'(NUM_CH - 1));
        sample_upd = (state_q == ACCUM) && last_idx;
        if (sh_mute_q)                sample_d = '0;
        else if (|scaled[WW-1:OUT_W]) sample_d = '1;
        else                          sample_d = scaled[OUT_W-1:0];
    end

    // SCALE is the cycle in which the finished sample is presented on the outputs.
    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            audio_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (tick) state_q <= SNAP;
                SNAP: begin
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (last_idx) begin
                        audio_q <= sample_d;
                        valid_q <= 1'b1;
                        state_q <= SCALE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                SCALE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign audio_o        = audio_q;
    assign sample_valid_o = valid_q;

`ifdef PSG_MIXER_PEAK_EN
    logic [OUT_W-1:0] peak_q;
    logic [OUT_W-1:0] peak_d;

    // A clear coinciding with a sample update leaves the new sample as the peak.
    always_comb begin
        peak_d = peak_q;
        if (bus.reg_wr && bus.reg_addr == ADDR_PEAK) peak_d = '0;
        if (sample_upd && sample_d > peak_d)         peak_d = sample_d;
    end

    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) peak_q <= '0;
        else                peak_q <= peak_d;
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

    always_comb begin
        rdata_d = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.reg_addr == 4'(k)) rdata_d = {4'b0, gain_q[k]};
        end
        if (bus.reg_addr == ADDR_MUTE) rdata_d = {7'b0, mute_q};
`ifdef PSG_MIXER_PEAK_EN
        if (bus.reg_addr == ADDR_PEAK) rdata_d = peak_q[OUT_W-1 -: 8];
`endif
    end

    assign bus.reg_rdata = rdata_d;
endmodule
